// File: rtl/datapath_ctrl_pkg.sv
// datapath_ctrl_pkg: shared state, opcode, select and decode-class encodings for the datapath sequencer
package datapath_ctrl_pkg;
    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;
    typedef enum logic [1:0] {CLS_IMM, CLS_AB, CLS_B, CLS_ILL} cls_t;
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b01;
    localparam logic [1:0] ALU_ADD    = 2'b00;
endpackage

// File: rtl/datapath_ctrl_instr_dec.sv
// datapath_ctrl_instr_dec: combinational field extraction, immediate sign extension and class decode of ir
module datapath_ctrl_instr_dec
    import datapath_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] ir,
    output logic [2:0]       rn,
    output logic [2:0]       rd,
    output logic [2:0]       rm,
    output logic [1:0]       op,
    output logic [1:0]       sh,
    output logic [WIDTH-1:0] sximm8,
    output cls_t             cls,
    output logic             is_cmp,
    output logic             is_mov_reg
);
    logic [2:0] opc;
    assign opc    = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};
    assign is_cmp     = opc == OPC_ALU && op == OP_CMP;
    assign is_mov_reg = opc == OPC_MOV && op == OP_MOV_REG;
    always_comb begin
        cls = CLS_ILL;
        if (opc == OPC_MOV && op == OP_MOV_IMM) cls = CLS_IMM;
        else if (is_mov_reg) cls = CLS_B;
        else if (opc == OPC_ALU) cls = op == OP_MVN ? CLS_B : CLS_AB;
    end
endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: Moore sequencer that latches one instruction per s/w handshake and strobes the datapath
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [WIDTH-1:0] in,
    output logic             w,
    output logic             err,
    output logic [2:0]       regnum,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       vsel,
    output logic [1:0]       ALUop,
    output logic [1:0]       shift,
    output logic [WIDTH-1:0] sximm8
);
    state_t state, ns;
    logic [WIDTH-1:0] ir;
    logic [2:0] rn, rd, rm;
    logic [1:0] op, sh;
    cls_t cls;
    logic is_cmp, is_mov_reg;

    datapath_ctrl_instr_dec #(.WIDTH(WIDTH)) u_dec (
        .ir(ir), .rn(rn), .rd(rd), .rm(rm), .op(op), .sh(sh), .sximm8(sximm8),
        .cls(cls), .is_cmp(is_cmp), .is_mov_reg(is_mov_reg)
    );

    assign bsel = 1'b0;

    always_comb begin
        ns = S_WAIT;
        unique case (state)
            S_WAIT:   ns = s ? S_DECODE : S_WAIT;
            S_DECODE: ns = cls == CLS_IMM ? S_WRITE_IMM : cls == CLS_AB ? S_GET_A :
                           cls == CLS_B ? S_GET_B : S_WAIT;
            S_GET_A:  ns = S_GET_B;
            S_GET_B:  ns = S_ALU;
            S_ALU:    ns = is_cmp ? S_WAIT : S_WRITE_REG;
            default:  ns = S_WAIT;
        endcase
    end

    // Outputs are registered from the next state so every strobe is glitch-free and aligned with state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_WAIT;
            ir     <= '0;
            w      <= 1'b1;
            err    <= 1'b0;
            regnum <= '0;
            write  <= 1'b0;
            loada  <= 1'b0;
            loadb  <= 1'b0;
            loadc  <= 1'b0;
            loads  <= 1'b0;
            asel   <= 1'b0;
            vsel   <= VSEL_C;
            ALUop  <= ALU_ADD;
            shift  <= 2'b00;
        end else begin
            state <= ns;
            if (state == S_WAIT && s) begin
                ir  <= in;
                err <= 1'b0;
            end
            if (state == S_DECODE && cls == CLS_ILL) err <= 1'b1;
            w      <= ns == S_WAIT;
            regnum <= (ns == S_WRITE_IMM || ns == S_GET_A) ? rn : ns == S_GET_B ? rm :
                      ns == S_WRITE_REG ? rd : 3'd0;
            write  <= ns == S_WRITE_IMM || ns == S_WRITE_REG;
            loada  <= ns == S_GET_A;
            loadb  <= ns == S_GET_B;
            loadc  <= ns == S_ALU;
            loads  <= ns == S_ALU && is_cmp;
            asel   <= ns == S_ALU && is_mov_reg;
            vsel   <= ns == S_WRITE_IMM ? VSEL_IMM : VSEL_C;
            ALUop  <= ns == S_ALU ? op : ALU_ADD;
            shift  <= (ns == S_GET_B || ns == S_ALU) ? sh : 2'b00;
        end
    end
endmodule
